seg_scan_reader: RTL and testbench

- Reads a time-multiplexed 7-segment display bus (active-low segment pattern plus one-hot digit strobe) and recovers the BCD value of each digit. It is the receive end of the digit-to-segment encoding used by the display driver.
- Filters glitches with a stability counter and stores one nibble per digit.
- Flags patterns that match no digit.
- Used as a loop-back checker for display paths and in self-test benches.

---
 rtl/seg_scan_reader.sv | 215 +++++++++++++++++++++
 tb/tb_seg_scan_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers BCD digits from a time-multiplexed, active-low 7-segment bus.
// Optional macro SEG_FRAME_EN enables the seen mask and the frame_done pulse.
module seg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              hex_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd_valid,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  localparam logic [3:0]            STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // Returns {err, nibble}; blank decodes to F without error.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: seg_decode = {1'b0, 4'h0};
      7'b1111001: seg_decode = {1'b0, 4'h1};
      7'b0100100: seg_decode = {1'b0, 4'h2};
      7'b0110000: seg_decode = {1'b0, 4'h3};
      7'b0011001: seg_decode = {1'b0, 4'h4};
      7'b0010010: seg_decode = {1'b0, 4'h5};
      7'b0000010: seg_decode = {1'b0, 4'h6};
      7'b1111000: seg_decode = {1'b0, 4'h7};
      7'b0000000: seg_decode = {1'b0, 4'h8};
      7'b0011000: seg_decode = {1'b0, 4'h9};
      7'b1111111: seg_decode = {1'b0, 4'hF};
      default:    seg_decode = {1'b1, 4'hE};
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
    is_one_hot = (v != '0) && ((v & (v - SEL_ONE)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] sel_index(input logic [NUM_DIGITS-1:0] v);
    sel_index = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) begin
        sel_index = IDX_W'(i);
      end
    end
  endfunction

  logic [6:0]            s_hex;
  logic [NUM_DIGITS-1:0] s_sel;
  logic [6:0]            prev_hex;
  logic [NUM_DIGITS-1:0] prev_sel;
  state_t                state;
  state_t                next_state;
  logic [3:0]            cnt;
  logic [3:0]            next_cnt;
  logic                  sel_ok;
  logic                  same_pair;
  logic                  capture;
  logic [IDX_W-1:0]      cap_idx;
  logic [4:0]            dec;

  assign sel_ok    = is_one_hot(s_sel);
  assign same_pair = (s_sel == prev_sel) && (s_hex == prev_hex);

  // Input sampling stage
  always_ff @(posedge clk) begin
    if (reset) begin
      s_hex <= 7'd0;
      s_sel <= '0;
    end else begin
      s_hex <= hex_in;
      s_sel <= dig_sel;
    end
  end

  // State register, stability counter and previous pair
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      prev_hex <= 7'd0;
      prev_sel <= '0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      prev_hex <= s_hex;
      prev_sel <= s_sel;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          next_state = TRACK;
          next_cnt   = 4'd1;
        end else begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end
      end
      TRACK: begin
        if (!sel_ok) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else if (!same_pair) begin
          next_state = TRACK;
          next_cnt   = 4'd1;
        end else if (cnt + 4'd1 >= STABLE_N) begin
          next_state = HELD;
          next_cnt   = STABLE_N;
        end else begin
          next_state = TRACK;
          next_cnt   = cnt + 4'd1;
        end
      end
      HELD: begin
        if (!sel_ok) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else if (!same_pair) begin
          next_state = TRACK;
          next_cnt   = 4'd1;
        end else begin
          next_state = HELD;
          next_cnt   = STABLE_N;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // Output decode: the capture fires on the edge that completes the stable run
  always_comb begin
    dec     = seg_decode(s_hex);
    cap_idx = sel_index(s_sel);
    if ((state == TRACK) && sel_ok && same_pair && (cnt + 4'd1 >= STABLE_N)) begin
      capture = 1'b1;
    end else begin
      capture = 1'b0;
    end
  end

  // Captured digit storage and update pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_out   <= '1;
      digit_err <= '0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
    end else begin
      upd_valid <= capture;
      if (capture) begin
        upd_idx <= cap_idx;
      end else begin
        upd_idx <= upd_idx;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && s_sel[i]) begin
          bcd_out[4*i +: 4] <= dec[3:0];
          digit_err[i]      <= dec[4];
        end else begin
          bcd_out[4*i +: 4] <= bcd_out[4*i +: 4];
          digit_err[i]      <= digit_err[i];
        end
      end
    end
  end

`ifdef SEG_FRAME_EN
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;

  assign seen_next = seen | s_sel;

  // Seen mask; frame completes when every digit has been captured at least once
  always_ff @(posedge clk) begin
    if (reset) begin
      seen       <= '0;
      frame_done <= 1'b0;
    end else if (capture) begin
      if (&seen_next) begin
        seen       <= '0;
        frame_done <= 1'b1;
      end else begin
        seen       <= seen_next;
        frame_done <= 1'b0;
      end
    end else begin
      seen       <= seen;
      frame_done <= 1'b0;
    end
  end
`else
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// Randomized scoreboard bench for seg_scan_reader; expected captures come from a
// run-length model of the driven (dig_sel, hex_in) stream.
module tb_seg_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    hex_in = 7'h7F;
  logic [ND-1:0] dig_sel = '0;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0] digit_err;
  logic          upd_valid;
  logic [1:0]    upd_idx;
  logic          frame_done;

  seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dig_sel(dig_sel),
    .bcd_out(bcd_out), .digit_err(digit_err), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          due;
    logic [1:0]  idx;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        frame;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  logic [3:0]    m_nib [ND];
  logic [ND-1:0] m_err;
  logic [ND-1:0] m_seen;
  logic [ND-1:0] m_sel;
  logic [6:0]    m_hex;
  int            run = 0;
  logic          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] h);
    if (h == 7'h7F) return {1'b0, 4'hF};
    for (int d = 0; d < 10; d++)
      if (SEG_TAB[d] == h) return {1'b0, 4'(d)};
    return {1'b1, 4'hE};
  endfunction

  function automatic logic [15:0] model_bcd();
    logic [15:0] b;
    for (int i = 0; i < ND; i++) b[4*i +: 4] = m_nib[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_nib[i] = 4'hF;
    m_err = '0;
    m_seen = '0;
    run = 0;
    done = 1'b0;
  endtask

  // drive one sample; the value is taken by the DUT at edge e
  task automatic step(input logic [ND-1:0] sel, input logic [6:0] hex, input logic rst);
    int e;
    exp_t ent;
    logic [4:0] d;
    int idx;
    e = edge_cnt + 1;
    reset = rst;
    dig_sel = sel;
    hex_in = hex;
    if (rst) begin
      model_reset();
      while (q.size() > 0 && q[q.size()-1].due >= e) void'(q.pop_back());
    end else if ($countones(sel) == 1) begin
      if (run > 0 && sel == m_sel && hex == m_hex) run++;
      else begin
        run = 1;
        done = 1'b0;
      end
      m_sel = sel;
      m_hex = hex;
      if (run >= SC && !done) begin
        done = 1'b1;
        idx = 0;
        for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
        d = ref_decode(hex);
        m_nib[idx] = d[3:0];
        m_err[idx] = d[4];
        ent.frame = 1'b0;
`ifdef SEG_FRAME_EN
        m_seen[idx] = 1'b1;
        if (m_seen == '1) begin
          ent.frame = 1'b1;
          m_seen = '0;
        end
`endif
        ent.due = e + 1;
        ent.idx = 2'(idx);
        ent.bcd = model_bcd();
        ent.err = m_err;
        q.push_back(ent);
      end
    end else begin
      run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [ND-1:0] sel, input logic [6:0] hex, input int n);
    for (int i = 0; i < n; i++) step(sel, hex, 1'b0);
  endtask

  task automatic check_reset_values();
    chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_valid", 32'(upd_valid), 32'h0);
    chk("rst_idx", 32'(upd_idx), 32'h0);
    chk("rst_frame", 32'(frame_done), 32'h0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t x;
    if (upd_valid) begin
      if (q.size() == 0) chk("spurious_upd", 32'(upd_valid), 32'h0);
      else begin
        x = q.pop_front();
        chk("cap_edge", 32'(edge_cnt), 32'(x.due));
        chk("cap_idx", 32'(upd_idx), 32'(x.idx));
        chk("cap_bcd", 32'(bcd_out), 32'(x.bcd));
        chk("cap_err", 32'(digit_err), 32'(x.err));
        chk("cap_frame", 32'(frame_done), 32'(x.frame));
      end
    end else if (q.size() > 0 && q[0].due <= edge_cnt) begin
      chk("missing_upd", 32'(upd_valid), 32'h1);
      void'(q.pop_front());
    end else begin
      chk("idle_frame", 32'(frame_done), 32'h0);
      if (q.size() == 0 && !reset) begin
        chk("idle_bcd", 32'(bcd_out), 32'(model_bcd()));
        chk("idle_err", 32'(digit_err), 32'(m_err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [ND-1:0] sel;
    logic [6:0] hex;
    int r;
    model_reset();
    @(posedge clk);
    #1;
    step('0, 7'h7F, 1'b1);
    step('0, 7'h7F, 1'b1);
    step('0, 7'h7F, 1'b0);
    check_reset_values();

    hold(4'b0001, 7'b0100100, 14);
    hold(4'b0000, 7'h7F, 3);
    chk("digit0_is_2", 32'(bcd_out[3:0]), 32'h2);
    hold(4'b0100, 7'b0110000, 3);
    hold(4'b0100, 7'b0011001, 4);
    hold(4'b0000, 7'h7F, 3);
    chk("digit2_is_4", 32'(bcd_out[11:8]), 32'h4);
    hold(4'b0010, 7'b0000001, 4);
    hold(4'b0000, 7'h7F, 3);
    chk("digit1_err", 32'({digit_err[1], bcd_out[7:4]}), 32'h1E);
    hold(4'b0010, 7'b0011000, 4);
    hold(4'b0000, 7'h7F, 3);
    chk("digit1_ok", 32'({digit_err[1], bcd_out[7:4]}), 32'h09);
    hold(4'b0011, SEG_TAB[5], 10);
    hold(4'b0000, SEG_TAB[5], 10);

    step('0, 7'h7F, 1'b1);
    step('0, 7'h7F, 1'b1);
    for (int i = 0; i < ND; i++) hold(4'(1 << i), SEG_TAB[i+1], 5);
    hold(4'b0000, 7'h7F, 3);
    chk("frame_bcd", 32'(bcd_out), 32'h4321);

    hold(4'b0001, SEG_TAB[7], 2);
    step('0, 7'h7F, 1'b1);
    step('0, 7'h7F, 1'b1);
    hold(4'b0000, 7'h7F, 6);
    check_reset_values();

    for (int ep = 0; ep < 300; ep++) begin
      if ($urandom_range(0, 49) == 0) begin
        step('0, 7'h7F, 1'b1);
        step('0, 7'h7F, 1'b1);
      end
      r = $urandom_range(0, 9);
      if (r < 7) sel = 4'(1 << $urandom_range(0, ND-1));
      else if (r == 7) sel = '0;
      else sel = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 11);
      if (r < 10) hex = SEG_TAB[r];
      else if (r == 10) hex = 7'h7F;
      else hex = 7'($urandom_range(0, 127));
      hold(sel, hex, $urandom_range(1, 7));
    end

    hold(4'b0000, 7'h7F, 8);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
